// File: rtl/accumulator_pkg.sv
// Shared encodings for the N-operand accumulator processor: bus commands,
// one-hot FSM states and the operand-counter width helper.
package accumulator_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 7;

  typedef enum logic [OP_W-1:0] {
    NOP   = 2'b00,
    FETCH = 2'b01,
    SEND  = 2'b10
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 7'b0000001,
    REQF    = 7'b0000010,
    FETCH_S = 7'b0000100,
    ACC     = 7'b0001000,
    REQS    = 7'b0010000,
    SEND_S  = 7'b0100000,
    DONE    = 7'b1000000
  } state_e;

  // Counter must hold values 0..num_ops.
  function automatic int unsigned count_width(input int unsigned num_ops);
    return $clog2(num_ops + 1);
  endfunction

endpackage

// File: rtl/acc_sat_adder.sv
// Unsigned DATA_W-bit adder with carry-out; optionally clamps to all-ones
// when the true sum does not fit.
module acc_sat_adder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum_c,
  output logic              carry_c
);

  logic [DATA_W:0] full;

  assign full    = {1'b0, a} + {1'b0, b};
  assign carry_c = full[DATA_W];

  if (SAT_MODE != 0) begin : g_sat
    assign sum_c = full[DATA_W] ? '1 : full[DATA_W-1:0];
  end else begin : g_wrap
    assign sum_c = full[DATA_W-1:0];
  end

endmodule

// File: rtl/accumulator_processor_n.sv
// Bus-master that fetches NUM_OPS operands over a request/grant bus,
// accumulates them (wrap or saturate) and writes the sum back.
module accumulator_processor_n
  import accumulator_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_OPS  = 2,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [OP_W-1:0]    op,
  input  logic               signal,
  input  logic [DATA_W-1:0]  read,
  output logic [DATA_W-1:0]  write,
  output logic               req,
  input  logic               grant,
  output logic               done,
  output logic               ovf,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned          CNT_W = count_width(NUM_OPS);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(NUM_OPS - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   write_q, write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   sum_c;
  logic                carry_c;

  acc_sat_adder #(
    .DATA_W  (DATA_W),
    .SAT_MODE(SAT_MODE)
  ) u_add (
    .a      (acc_q),
    .b      (opnd_q),
    .sum_c  (sum_c),
    .carry_c(carry_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= NOP;
      acc_q   <= '0;
      opnd_q  <= '0;
      write_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  // Next state and datapath; bus outputs are then decoded from the next state
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    write_d = write_q;
    op_d    = NOP;
    req_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQF;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          write_d = '0;
        end
      end
      REQF: begin
        if (grant) state_d = FETCH_S;
      end
      FETCH_S: begin
        if (signal) begin
          opnd_d  = read;
          state_d = ACC;
        end else if (!grant) begin
          state_d = REQF;
        end
      end
      ACC: begin
        acc_d   = sum_c;
        ovf_d   = ovf_q | carry_c;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == LAST) ? REQS : REQF;
      end
      REQS: begin
        if (grant) state_d = SEND_S;
      end
      SEND_S: begin
        if (signal) state_d = DONE;
        else if (!grant) state_d = REQS;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      REQF: begin
        req_d = 1'b1;
      end
      FETCH_S: begin
        req_d = 1'b1;
        op_d  = FETCH;
      end
      REQS: begin
        req_d   = 1'b1;
        write_d = acc_d;
      end
      SEND_S: begin
        req_d   = 1'b1;
        op_d    = SEND;
        write_d = acc_d;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign op    = op_q;
  assign write = write_q;
  assign req   = req_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign state = state_q;

endmodule

// File: tb/tb_accumulator_processor_n.sv
// Randomised bench: three processor instances (32b/2 ops wrap, 16b/4 ops wrap
// and saturate) against a transaction-level sum/latency model.
module tb_accumulator_processor_n;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_b[2];
  logic        grant_b[2];
  logic        signal_b[2];
  logic [31:0] read_b[2];

  logic [1:0]  op_a[3];
  logic        req_a[3];
  logic        done_a[3];
  logic        ovf_a[3];
  logic [6:0]  st_a[3];
  logic [31:0] wr_a[3];
  logic [15:0] wr_w, wr_s;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus knobs and operand tables per bus (bus 0 -> lane 0, bus 1 -> lanes 1,2)
  int          gp[2], sp[2], noise[2];
  bit          drop_pend[2];
  logic [31:0] ops_b[2][4];

  // Model state per lane
  bit          busy[3], have_res[3], fast[3];
  int          fetched[3], runs[3], lat[3], done_lat[3];
  logic [31:0] exp_sum[3];
  logic        exp_ovf[3];
  logic [1:0]  p_op[3];
  logic [31:0] p_wr[3];
  logic        p_done[3];

  always #5 clk = ~clk;

  accumulator_processor_n #(.DATA_W(32), .NUM_OPS(2), .SAT_MODE(0)) dut_x (
    .clk(clk), .reset(reset), .start(start_b[0]), .op(op_a[0]), .signal(signal_b[0]),
    .read(read_b[0]), .write(wr_a[0]), .req(req_a[0]), .grant(grant_b[0]),
    .done(done_a[0]), .ovf(ovf_a[0]), .state(st_a[0]));

  accumulator_processor_n #(.DATA_W(16), .NUM_OPS(4), .SAT_MODE(0)) dut_w (
    .clk(clk), .reset(reset), .start(start_b[1]), .op(op_a[1]), .signal(signal_b[1]),
    .read(read_b[1][15:0]), .write(wr_w), .req(req_a[1]), .grant(grant_b[1]),
    .done(done_a[1]), .ovf(ovf_a[1]), .state(st_a[1]));

  accumulator_processor_n #(.DATA_W(16), .NUM_OPS(4), .SAT_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_b[1]), .op(op_a[2]), .signal(signal_b[1]),
    .read(read_b[1][15:0]), .write(wr_s), .req(req_a[2]), .grant(grant_b[1]),
    .done(done_a[2]), .ovf(ovf_a[2]), .state(st_a[2]));

  assign wr_a[1] = {16'h0000, wr_w};
  assign wr_a[2] = {16'h0000, wr_s};

  function automatic int nops_of(input int l);
    return (l == 0) ? 2 : 4;
  endfunction

  function automatic int w_of(input int l);
    return (l == 0) ? 32 : 16;
  endfunction

  // Reference sum: plain wide arithmetic, carry when the running total leaves range.
  function automatic void fold(input int l, output logic [31:0] s, output logic v);
    longint unsigned lim = 64'd1 << w_of(l);
    longint unsigned acc = 0;
    int b = (l == 0) ? 0 : 1;
    v = 1'b0;
    for (int i = 0; i < nops_of(l); i++) begin
      acc = acc + (64'(ops_b[b][i]) & (lim - 1));
      if (acc >= lim) begin
        v   = 1'b1;
        acc = (l == 2) ? lim - 1 : acc - lim;
      end
    end
    s = 32'(acc);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: outputs settle after the edge; inputs sampled at that edge are still held.
  always @(posedge clk) begin
    int  b;
    bit  ed;
    #1;
    for (int l = 0; l < 3; l++) begin
      b  = (l == 0) ? 0 : 1;
      ed = 1'b0;
      if (!reset) begin
        busy[l]     = 1'b0;
        have_res[l] = 1'b0;
        fetched[l]  = 0;
        chk("rst_req", 64'(req_a[l]), 64'd0);
        chk("rst_op", 64'(op_a[l]), 64'(OP_NOP));
        chk("rst_done", 64'(done_a[l]), 64'd0);
        chk("rst_ovf", 64'(ovf_a[l]), 64'd0);
        chk("rst_write", 64'(wr_a[l]), 64'd0);
        chk("rst_state", 64'(st_a[l]), 64'h01);
      end else begin
        if (!busy[l] && start_b[b]) begin
          busy[l]     = 1'b1;
          have_res[l] = 1'b0;
          fetched[l]  = 0;
          lat[l]      = 1;
          fast[l]     = (gp[b] == 100) && (sp[b] == 100) && !drop_pend[b];
          fold(l, exp_sum[l], exp_ovf[l]);
        end else if (busy[l]) begin
          lat[l]++;
          if (p_done[l]) begin
            busy[l] = 1'b0;
          end else if (p_op[l] == OP_FETCH && signal_b[b]) begin
            fetched[l]++;
          end else if (p_op[l] == OP_SEND && signal_b[b]) begin
            ed = 1'b1;
            chk("send_write", 64'(p_wr[l]), 64'(exp_sum[l]));
            chk("fetch_count", 64'(fetched[l]), 64'(nops_of(l)));
          end
        end
        chk("done", 64'(done_a[l]), 64'(ed));
        if (ed) begin
          chk("ovf_end", 64'(ovf_a[l]), 64'(exp_ovf[l]));
          if (fast[l]) chk("latency", 64'(lat[l]), 64'(3 * nops_of(l) + 3));
          done_lat[l] = lat[l];
          have_res[l] = 1'b1;
          runs[l]++;
        end
        if (!busy[l]) begin
          chk("idle_req", 64'(req_a[l]), 64'd0);
          chk("idle_op", 64'(op_a[l]), 64'(OP_NOP));
          if (have_res[l]) begin
            chk("hold_write", 64'(wr_a[l]), 64'(exp_sum[l]));
            chk("hold_ovf", 64'(ovf_a[l]), 64'(exp_ovf[l]));
          end
        end
        chk("onehot", 64'($onehot(st_a[l])), 64'd1);
      end
      p_op[l]   = op_a[l];
      p_wr[l]   = wr_a[l];
      p_done[l] = done_a[l];
    end
  end

  // One cycle of bus behaviour: arbiter grant and memory strobe, with optional noise.
  task automatic tick(input bit s0, input bit s1);
    bit busop;
    @(negedge clk);
    start_b[0] = s0;
    start_b[1] = s1;
    for (int b = 0; b < 2; b++) begin
      busop       = (op_a[b] == OP_FETCH) || (op_a[b] == OP_SEND);
      grant_b[b]  = req_a[b] && ($urandom_range(0, 99) < 32'(gp[b]));
      signal_b[b] = busop ? ($urandom_range(0, 99) < 32'(sp[b]))
                          : ($urandom_range(0, 99) < 32'(noise[b]));
      if (drop_pend[b] && op_a[b] == OP_FETCH && fetched[b] == 1) begin
        grant_b[b]   = 1'b0;
        signal_b[b]  = 1'b0;
        drop_pend[b] = 1'b0;
      end
      read_b[b] = (fetched[b] < 4) ? ops_b[b][fetched[b]] : $urandom;
    end
  endtask

  task automatic run(input int b, input int gpv, input int spv, input int nz, input bit drop,
                     input bit twice, input logic [31:0] o0, input logic [31:0] o1,
                     input logic [31:0] o2, input logic [31:0] o3);
    int c0 = runs[b];
    int t  = 0;
    ops_b[b]     = '{o0, o1, o2, o3};
    gp[b]        = gpv;
    sp[b]        = spv;
    noise[b]     = nz;
    drop_pend[b] = drop;
    tick(b == 0, b == 1);
    if (twice) tick(b == 0, b == 1);
    tick(1'b0, 1'b0);
    while (runs[b] == c0 && t < 600) begin
      tick(1'b0, 1'b0);
      t++;
    end
    repeat (3) tick(1'b0, 1'b0);
    chk("runs_once", 64'(runs[b] - c0), 64'd1);
    drop_pend[b] = 1'b0;
    noise[b]     = 0;
  endtask

  function automatic logic [31:0] rnd(input int b);
    logic [31:0] v = $urandom;
    if ($urandom_range(0, 1) == 0) v = v >> $urandom_range(4, 20);
    return (b == 0) ? v : {16'h0000, v[15:0]};
  endfunction

  initial begin
    int c0;
    int t;
    reset = 1'b0;
    for (int b = 0; b < 2; b++) begin
      start_b[b] = 1'b0; grant_b[b] = 1'b0; signal_b[b] = 1'b0; read_b[b] = '0;
      gp[b] = 100; sp[b] = 100; noise[b] = 0; drop_pend[b] = 1'b0;
      ops_b[b] = '{32'd0, 32'd0, 32'd0, 32'd0};
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 1'b0);

    // 100 + 250 with immediate grant and strobe
    run(0, 100, 100, 0, 1'b0, 1'b0, 32'd100, 32'd250, 32'd0, 32'd0);
    chk("lit_sum350", 64'(wr_a[0]), 64'd350);
    chk("lit_ovf0", 64'(ovf_a[0]), 64'd0);
    chk("lit_latency9", 64'(done_lat[0]), 64'd9);

    // Wrap vs saturate on the same operand stream
    run(1, 100, 100, 0, 1'b0, 1'b0, 32'hFFFF, 32'd2, 32'd3, 32'd4);
    chk("lit_wrap", 64'(wr_a[1]), 64'h0008);
    chk("lit_wrap_ovf", 64'(ovf_a[1]), 64'd1);
    chk("lit_sat", 64'(wr_a[2]), 64'hFFFF);
    chk("lit_sat_ovf", 64'(ovf_a[2]), 64'd1);

    // Grant lost while waiting on the second operand
    run(1, 100, 100, 0, 1'b1, 1'b0, 32'd10, 32'd20, 32'd30, 32'd40);
    chk("lit_refetch", 64'(wr_a[1]), 64'd100);
    chk("lit_refetch_ovf", 64'(ovf_a[1]), 64'd0);

    // Strobe in IDLE and a second start in REQF are ignored
    noise[0] = 100;
    repeat (2) tick(1'b0, 1'b0);
    run(0, 100, 100, 0, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0, 32'd0);
    chk("lit_ignore", 64'(wr_a[0]), 64'd11);
    chk("lit_ignore_lat", 64'(done_lat[0]), 64'd9);

    // Reset while SEND is on the bus aborts the run
    ops_b[0] = '{32'd1, 32'd2, 32'd0, 32'd0};
    gp[0] = 100; sp[0] = 100;
    c0 = runs[0];
    tick(1'b1, 1'b0);
    t = 0;
    while (op_a[0] != OP_SEND && t < 50) begin
      tick(1'b0, 1'b0);
      t++;
    end
    chk("reach_send", 64'(op_a[0]), 64'(OP_SEND));
    reset = 1'b0;
    #1;
    chk("abort_op", 64'(op_a[0]), 64'(OP_NOP));
    chk("abort_req", 64'(req_a[0]), 64'd0);
    repeat (2) tick(1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    chk("abort_no_done", 64'(runs[0]), 64'(c0));
    run(0, 100, 100, 0, 1'b0, 1'b0, 32'd7, 32'd8, 32'd0, 32'd0);
    chk("lit_after_reset", 64'(wr_a[0]), 64'd15);

    // Randomised bus timing and operands
    for (int r = 0; r < 12; r++)
      run(0, $urandom_range(40, 100), $urandom_range(40, 100), 20, 1'($urandom_range(0, 1)),
          1'b0, rnd(0), rnd(0), 32'd0, 32'd0);
    for (int r = 0; r < 14; r++)
      run(1, $urandom_range(40, 100), $urandom_range(40, 100), 20, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), rnd(1), rnd(1), rnd(1), rnd(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
